// File: rtl/comparator_serial.sv
// -----------------------------------------------------------------------------
// comparator_serial
//   Multi-cycle magnitude comparator. Operands are latched on an accepted
//   start and compared one CHUNK-bit slice per clock, most significant slice
//   first. The comparison stops at the first slice that differs.
//
// Parameters
//   WIDTH  total operand width in bits (must be a multiple of CHUNK)
//   CHUNK  bits compared per clock cycle (>= 1)
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        request a comparison (accepted only when idle)
//   signed_mode  1 = two's-complement compare, 0 = unsigned compare
//   a, b         operands
//   busy         comparison in progress
//   done         one-cycle pulse, result valid
//   lt, eq, gr   result flags, held until the next accepted start
// -----------------------------------------------------------------------------
module comparator_serial #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             eq,
   output logic             gr
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CMP  = 1'b1
   } state_t;

   state_t            state_q;
   logic [IDXW-1:0]   idx_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic              sm_q;
   logic              busy_q;
   logic              done_q;
   logic              lt_q;
   logic              eq_q;
   logic              gr_q;

   logic [WIDTH-1:0]  a_flip_s;
   logic [WIDTH-1:0]  b_flip_s;
   logic [CHUNK-1:0]  a_chunk_s;
   logic [CHUNK-1:0]  b_chunk_s;
   logic              chunk_ne_s;
   logic              chunk_lt_s;
   logic              last_chunk_s;

   // Slice selection and per-slice compare for the current index.
   // Flipping the sign bit maps two's-complement order onto unsigned order;
   // the sign bit lives only in the top slice, so lower slices are unaffected.
   always_comb begin
      a_flip_s = a_q;
      b_flip_s = b_q;
      if (sm_q) begin
         a_flip_s[WIDTH-1] = ~a_q[WIDTH-1];
         b_flip_s[WIDTH-1] = ~b_q[WIDTH-1];
      end else begin
         a_flip_s = a_q;
         b_flip_s = b_q;
      end
      a_chunk_s    = a_flip_s[idx_q*CHUNK +: CHUNK];
      b_chunk_s    = b_flip_s[idx_q*CHUNK +: CHUNK];
      chunk_ne_s   = (a_chunk_s != b_chunk_s);
      chunk_lt_s   = (a_chunk_s <  b_chunk_s);
      last_chunk_s = (idx_q == {IDXW{1'b0}});
   end

   // Control FSM with registered status and result outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         idx_q   <= {IDXW{1'b0}};
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         sm_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
         gr_q    <= 1'b0;
      end else begin
         // done is a single-cycle pulse unless re-asserted below
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // Also reached in the done cycle, giving back-to-back accepts
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  sm_q    <= signed_mode;
                  idx_q   <= IDXW'(NCHUNK - 1);
                  lt_q    <= 1'b0;
                  eq_q    <= 1'b0;
                  gr_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= CMP;
               end else begin
                  state_q <= IDLE;
               end
            end
            CMP: begin
               if (chunk_ne_s) begin
                  // First differing slice decides the whole result
                  lt_q    <= chunk_lt_s;
                  gr_q    <= ~chunk_lt_s;
                  eq_q    <= 1'b0;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (last_chunk_s) begin
                  eq_q    <= 1'b1;
                  lt_q    <= 1'b0;
                  gr_q    <= 1'b0;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  idx_q   <= idx_q - IDXW'(1);
                  state_q <= CMP;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign lt   = lt_q;
   assign eq   = eq_q;
   assign gr   = gr_q;

endmodule

// File: tb/tb_comparator_serial.sv
// -----------------------------------------------------------------------------
// tb_comparator_serial
//   Directed and reference-model checks for comparator_serial at
//   WIDTH=16, CHUNK=4. Inputs are driven on the falling edge; outputs are
//   sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_comparator_serial;

   localparam int WIDTH = 16;
   localparam int CHUNK = 4;
   localparam int LAT_LIMIT = 12;

   localparam logic [2:0] R_LT = 3'b100;
   localparam logic [2:0] R_EQ = 3'b010;
   localparam logic [2:0] R_GR = 3'b001;

   logic             clk;
   logic             reset_n;
   logic             start;
   logic             signed_mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             lt;
   logic             eq;
   logic             gr;

   int checks;
   int errors;

   comparator_serial #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .signed_mode (signed_mode),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .lt          (lt),
      .eq          (eq),
      .gr          (gr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full-width reference compare
   function automatic logic [2:0] ref_cmp(input logic [15:0] x, input logic [15:0] y, input logic sm);
      if (sm) begin
         if ($signed(x) < $signed(y))       return R_LT;
         else if ($signed(x) == $signed(y)) return R_EQ;
         else                               return R_GR;
      end else begin
         if (x < y)       return R_LT;
         else if (x == y) return R_EQ;
         else             return R_GR;
      end
   endfunction

   // Latency = 1 + number of leading equal nibbles, capped at 4
   function automatic int ref_lat(input logic [15:0] x, input logic [15:0] y);
      for (int i = 3; i >= 0; i--) begin
         if (x[i*4 +: 4] != y[i*4 +: 4]) return 4 - i;
      end
      return 4;
   endfunction

   // One full transaction: accept, count cycles to done, check result.
   task automatic run_cmp(input logic [15:0] av, input logic [15:0] bv, input logic sm,
                          input logic [2:0] exp_res, input int exp_lat, input string tag);
      int lat;
      int busy_cnt;
      @(negedge clk);
      a = av; b = bv; signed_mode = sm; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_accept_busy"}, 32'(busy), 32'd1);
      check({tag, "_accept_flags"}, 32'({lt, eq, gr}), 32'd0);
      busy_cnt = 1;
      lat = 0;
      while (1) begin
         @(posedge clk); #1;
         lat++;
         if (done) break;
         if (busy) busy_cnt++;
         if (lat >= LAT_LIMIT) break;
      end
      check({tag, "_done_seen"}, 32'(done), 32'd1);
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_result"}, 32'({lt, eq, gr}), 32'(exp_res));
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_hold"}, 32'({lt, eq, gr}), 32'(exp_res));
   endtask

   initial begin
      int lat;
      int done_cnt;
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rs;
      logic [15:0] corners [4];

      checks = 0;
      errors = 0;
      start = 1'b0;
      signed_mode = 1'b0;
      a = 16'h0000;
      b = 16'h0000;
      reset_n = 1'b0;
      corners[0] = 16'h0000;
      corners[1] = 16'h7FFF;
      corners[2] = 16'h8000;
      corners[3] = 16'hFFFF;

      // Reset state
      #12;
      check("reset_outputs", 32'({busy, done, lt, eq, gr}), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Directed vectors
      run_cmp(16'h1234, 16'h1234, 1'b0, R_EQ, 4, "equal");
      run_cmp(16'hA000, 16'h1000, 1'b0, R_GR, 1, "early_unsigned");
      run_cmp(16'hA000, 16'h1000, 1'b1, R_LT, 1, "early_signed");
      run_cmp(16'h1235, 16'h1234, 1'b0, R_GR, 4, "lsb_unsigned");
      run_cmp(16'hFFFE, 16'hFFFF, 1'b1, R_LT, 4, "lsb_signed");
      run_cmp(16'h8000, 16'h7FFF, 1'b1, R_LT, 1, "sign_boundary");
      run_cmp(16'h8000, 16'h7FFF, 1'b0, R_GR, 1, "unsigned_boundary");

      // Start held through busy is ignored, then accepted in the done cycle
      @(negedge clk);
      a = 16'h0001; b = 16'h0002; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      a = 16'h0002; b = 16'h0001;
      lat = 0;
      while (1) begin
         @(posedge clk); #1;
         lat++;
         if (done || lat >= LAT_LIMIT) break;
      end
      check("busy_first_done", 32'(done), 32'd1);
      check("busy_first_latency", 32'(lat), 32'd4);
      check("busy_first_result", 32'({lt, eq, gr}), 32'(R_LT));
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_accept_busy", 32'(busy), 32'd1);
      check("b2b_accept_flags", 32'({done, lt, eq, gr}), 32'd0);
      lat = 0;
      while (1) begin
         @(posedge clk); #1;
         lat++;
         if (done || lat >= LAT_LIMIT) break;
      end
      check("b2b_second_done", 32'(done), 32'd1);
      check("b2b_second_latency", 32'(lat), 32'd4);
      check("b2b_second_result", 32'({lt, eq, gr}), 32'(R_GR));

      // Asynchronous reset during a comparison
      @(negedge clk);
      a = 16'h1111; b = 16'h1112; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      reset_n = 1'b0;
      #1;
      check("reset_mid_outputs", 32'({busy, done, lt, eq, gr}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done || busy) done_cnt++;
      end
      check("reset_no_done", 32'(done_cnt), 32'd0);

      // First start after reset is accepted normally
      run_cmp(16'h1111, 16'h1112, 1'b0, R_LT, 4, "after_reset");

      // Corner-value pairs in both modes
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            for (int m = 0; m < 2; m++) begin
               ra = corners[i];
               rb = corners[j];
               rs = 1'(m);
               run_cmp(ra, rb, rs, ref_cmp(ra, rb, rs), ref_lat(ra, rb), "corner");
            end
         end
      end

      // Random triples; half the time b shares a prefix with a for longer runs
      for (int n = 0; n < 1000; n++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rs = 1'($urandom_range(1, 0));
         if (n % 2 == 1) begin
            rb = (ra & 16'hFFF0) | (rb & 16'h000F);
         end
         if (n % 4 == 3) begin
            rb = (ra & 16'hFF00) | (rb & 16'h00FF);
         end
         run_cmp(ra, rb, rs, ref_cmp(ra, rb, rs), ref_lat(ra, rb), "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
